// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and address types for the scoreboarded register file
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_MAX = 4;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-producer bits, claim/release priority, count and busy lookup
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    output logic [ADDR_W:0]          pend_cnt,
    output logic                     claim_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] pend_q, pend_d;
    logic [ADDR_W:0]  pend_cnt_q, pend_cnt_d;
    logic             claim_err_q, claim_err_d;
    logic             zero_claim;

    // Claim beats a same-cycle release; the protected zero entry never becomes pending.
    always_comb begin
        pend_d     = pend_q;
        pend_cnt_d = '0;
        zero_claim = (ZERO_REG != 0) && (claim_addr == ADDR_W'(ZERO_ADDR));
        for (int e = 0; e < DEPTH; e++) begin
            if (claim_en && claim_addr == ADDR_W'(e)) begin
                pend_d[e] = 1'b1;
            end else if (wr_en && wr_addr == ADDR_W'(e)) begin
                pend_d[e] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            pend_d[0] = 1'b0;
        end
        for (int e = 0; e < DEPTH; e++) begin
            pend_cnt_d = pend_cnt_d + {{ADDR_W{1'b0}}, pend_d[e]};
        end
        claim_err_d = claim_en && !zero_claim && pend_q[claim_addr]
                      && !(wr_en && wr_addr == claim_addr);
    end

    // Pending state, its population count and the error pulse all advance together.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pend_q      <= '0;
            pend_cnt_q  <= '0;
            claim_err_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            pend_cnt_q  <= pend_cnt_d;
            claim_err_q <= claim_err_d;
        end
    end

    // Busy per read port, hidden when a bypassed write-back is retiring that register now.
    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            logic [ADDR_W-1:0] a;
            a = rd_addr[i*ADDR_W +: ADDR_W];
            rd_busy[i] = pend_q[a];
            if ((BYPASS != 0) && wr_en && wr_addr == a) begin
                rd_busy[i] = 1'b0;
            end
            if ((ZERO_REG != 0) && a == ADDR_W'(ZERO_ADDR)) begin
                rd_busy[i] = 1'b0;
            end
        end
    end

    assign pend_cnt  = pend_cnt_q;
    assign claim_err = claim_err_q;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with write bypass and pending scoreboard
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    output logic [ADDR_W:0]          pend_cnt,
    output logic                     claim_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_zero;

    assign wr_zero = (ZERO_REG != 0) && (wr_addr == ADDR_W'(ZERO_ADDR));

    // Storage: clear everything on reset, otherwise accept the write-back unless it targets r0.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= '0;
            end
        end else if (wr_en && !wr_zero) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read muxes: stored value, optionally overridden by the in-flight write, r0 pinned to zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            logic [ADDR_W-1:0] a;
            a = rd_addr[i*ADDR_W +: ADDR_W];
            rd_data[i*DATA_W +: DATA_W] = mem_q[a];
            if ((BYPASS != 0) && wr_en && wr_addr == a) begin
                rd_data[i*DATA_W +: DATA_W] = wr_data;
            end
            if ((ZERO_REG != 0) && a == ADDR_W'(ZERO_ADDR)) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clock      (clock),
        .reset_n    (reset_n),
        .rd_addr    (rd_addr),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .pend_cnt   (pend_cnt),
        .claim_err  (claim_err)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb, bypass and non-bypass builds
module tb_regfile_sb;
    import regfile_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [9:0]  rd_addr;
    logic        wr_en;
    reg_addr_t   wr_addr;
    logic [31:0] wr_data;
    logic        claim_en;
    reg_addr_t   claim_addr;

    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic [5:0]  pend_cnt_a, pend_cnt_b;
    logic        claim_err_a, claim_err_b;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_busy(rd_busy_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .pend_cnt(pend_cnt_a),
        .claim_err(claim_err_a)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .pend_cnt(pend_cnt_b),
        .claim_err(claim_err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rd(input reg_addr_t a0, input reg_addr_t a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    initial begin
        reset_n = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        claim_en = 1'b0; claim_addr = '0;
        tick(); tick();
        reset_n = 1'b1;

        // Preload every entry with all ones.
        wr_en = 1'b1; wr_data = 32'hFFFF_FFFF;
        for (int e = 0; e < 32; e++) begin
            wr_addr = reg_addr_t'(e);
            tick();
        end
        wr_en = 1'b0;
        set_rd(5'd5, 5'd0);
        check("preload_r5", rd_data_a[31:0], 32'hFFFF_FFFF);
        check("preload_r0", rd_data_a[63:32], 32'h0);

        // Reset clears storage, pending state and count.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int e = 0; e < 32; e++) begin
            set_rd(reg_addr_t'(e), reg_addr_t'(31 - e));
            check("rst_data_a", rd_data_a[31:0], 32'h0);
            check("rst_data_a1", rd_data_a[63:32], 32'h0);
            check("rst_data_b", rd_data_b[31:0], 32'h0);
            check("rst_busy_a", {30'h0, rd_busy_a}, 32'h0);
        end
        check("rst_pend_cnt", {26'h0, pend_cnt_a}, 32'h0);
        check("rst_claim_err", {31'h0, claim_err_a}, 32'h0);

        // Write r5, attempt write to r0.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234_5678;
        tick();
        wr_addr = 5'd0; wr_data = 32'h0000_DEAD;
        tick();
        wr_en = 1'b0;
        set_rd(5'd5, 5'd0);
        check("wr_r5_a", rd_data_a[31:0], 32'h1234_5678);
        check("wr_r0_a", rd_data_a[63:32], 32'h0);
        check("wr_r5_b", rd_data_b[31:0], 32'h1234_5678);
        check("wr_r0_b", rd_data_b[63:32], 32'h0);

        // Same-cycle bypass of r7.
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5;
        set_rd(5'd7, 5'd5);
        check("byp_r7_a", rd_data_a[31:0], 32'hA5A5_A5A5);
        check("byp_r7_b", rd_data_b[31:0], 32'h0);
        tick();
        wr_en = 1'b0;
        #1;
        check("post_r7_a", rd_data_a[31:0], 32'hA5A5_A5A5);
        check("post_r7_b", rd_data_b[31:0], 32'hA5A5_A5A5);

        // Claim r3, then release via write-back.
        claim_en = 1'b1; claim_addr = 5'd3;
        tick();
        claim_en = 1'b0;
        set_rd(5'd3, 5'd5);
        check("clm_busy_a", {30'h0, rd_busy_a}, 32'h1);
        check("clm_busy_b", {30'h0, rd_busy_b}, 32'h1);
        check("clm_cnt", {26'h0, pend_cnt_a}, 32'h1);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h42;
        #1;
        check("rel_busy_a", {30'h0, rd_busy_a}, 32'h0);
        check("rel_busy_b", {30'h0, rd_busy_b}, 32'h1);
        tick();
        wr_en = 1'b0;
        #1;
        check("rel_cnt_a", {26'h0, pend_cnt_a}, 32'h0);
        check("rel_cnt_b", {26'h0, pend_cnt_b}, 32'h0);
        check("rel_busy_post", {30'h0, rd_busy_b}, 32'h0);
        check("rel_data", rd_data_b[31:0], 32'h42);

        // Claim and write r9 together: claim wins.
        claim_en = 1'b1; claim_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h77;
        tick();
        claim_en = 1'b0; wr_en = 1'b0;
        set_rd(5'd9, 5'd3);
        check("cw_data", rd_data_a[31:0], 32'h77);
        check("cw_busy", {30'h0, rd_busy_a}, 32'h1);
        check("cw_cnt", {26'h0, pend_cnt_a}, 32'h1);
        check("cw_err", {31'h0, claim_err_a}, 32'h0);

        // Double claim of r9 flags an error for one cycle.
        claim_en = 1'b1; claim_addr = 5'd9;
        tick();
        claim_en = 1'b0;
        #1;
        check("dbl_err", {31'h0, claim_err_a}, 32'h1);
        check("dbl_cnt", {26'h0, pend_cnt_a}, 32'h1);
        check("dbl_busy", {30'h0, rd_busy_a}, 32'h1);
        tick();
        check("dbl_err_clr", {31'h0, claim_err_a}, 32'h0);

        // Claim r1, r2, r4; claim of r0 ignored; then mid-sequence reset.
        claim_en = 1'b1;
        claim_addr = 5'd1; tick();
        claim_addr = 5'd2; tick();
        claim_addr = 5'd4; tick();
        claim_addr = 5'd0; tick();
        claim_en = 1'b0;
        set_rd(5'd1, 5'd0);
        check("multi_cnt", {26'h0, pend_cnt_a}, 32'h4);
        check("multi_busy", {30'h0, rd_busy_a}, 32'h1);
        check("zero_claim_err", {31'h0, claim_err_a}, 32'h0);
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h1111;
        tick();
        wr_en = 1'b0;
        check("multi_rel_cnt", {26'h0, pend_cnt_a}, 32'h3);
        reset_n = 1'b0;
        claim_en = 1'b1; claim_addr = 5'd6;
        tick();
        reset_n = 1'b1; claim_en = 1'b0;
        set_rd(5'd1, 5'd9);
        check("mrst_cnt", {26'h0, pend_cnt_a}, 32'h0);
        check("mrst_busy", {30'h0, rd_busy_a}, 32'h0);
        check("mrst_r1", rd_data_a[31:0], 32'h0);
        set_rd(5'd6, 5'd2);
        check("mrst_busy2", {30'h0, rd_busy_a}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-cycle MIPS register bank: DEPTH x DATA_W storage with NUM_RD combinational read ports and one write port.
- Adds synchronous active-low reset of every entry.
- Adds an optional write-to-read bypass.
- Adds a per-register pending scoreboard. The decode stage claims a destination when a multi-cycle producer (load, mult) issues; write-back releases it. Consumers see busy flags for stall generation.
- Sits between decode (reads, claims) and write-back (writes).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = a same-cycle write is visible on read ports and in busy flags; 0 = reads return stored value only.
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes and claims.

Ports:
- clock, in, 1, rising-edge clock.
- reset_n, in, 1, synchronous active-low reset.
- rd_addr, in, NUM_RD*ADDR_W, packed read addresses; port i = bits [i*ADDR_W +: ADDR_W].
- rd_data, out, NUM_RD*DATA_W, packed read data, same packing.
- rd_busy, out, NUM_RD, 1 = addressed register has a pending producer.
- wr_en, in, 1, write strobe.
- wr_addr, in, ADDR_W, write address.
- wr_data, in, DATA_W, write data.
- claim_en, in, 1, mark claim_addr pending.
- claim_addr, in, ADDR_W, register to claim.
- pend_cnt, out, ADDR_W+1, number of entries currently pending.
- claim_err, out, 1, registered one-cycle pulse: claim hit an already-pending, not-released entry.

Behaviour:
- Reset, sampled on clock edge with reset_n=0:
  - all entries <= 0; all pending bits <= 0; pend_cnt <= 0; claim_err <= 0.
  - wr_en and claim_en are ignored in the reset cycle.
- Read: combinational, zero latency, per port independent.
  - rd_data_i = mem[rd_addr_i].
  - If BYPASS and wr_en and wr_addr == rd_addr_i (and not the zero entry), rd_data_i = wr_data instead.
  - If ZERO_REG and rd_addr_i == 0, rd_data_i = 0 regardless of bypass.
- Write: on posedge, if wr_en and not (ZERO_REG and wr_addr == 0), mem[wr_addr] <= wr_data.
- Scoreboard, next state per entry e, evaluated in this order:
  - release = wr_en and wr_addr == e.
  - set = claim_en and claim_addr == e.
  - pend[e] <= set ? 1 : (release ? 0 : pend[e]).
  - Claim wins over a simultaneous release on the same entry: the new producer supersedes the one writing back.
  - A write to a non-pending entry is legal (single-cycle ALU result); pend is unchanged.
  - Entry 0 with ZERO_REG is never pending.
- Busy flags:
  - rd_busy_i = pend[rd_addr_i], except forced 0 when BYPASS and a releasing write to that address is present this cycle.
  - Forced 0 for the zero entry.
- claim_err:
  - <= 1 for exactly one cycle after an edge where claim_en hit an entry with pend = 1 and no same-cycle release.
  - Pend stays 1 in that case.
- pend_cnt: registered population count of pend[], updated on the same edge as pend[].
- Mid-operation reset drops all claims; producers in flight must be flushed by the pipeline. This is the block's contract, not checked.
- Addresses are always in range: DEPTH = 2**ADDR_W, so there is no out-of-range case.

Decomposition:
- Shared package regfile_pkg holds:
  - defaults DATA_W_DEF = 32, ADDR_W_DEF = 5, NUM_RD_MAX = 4;
  - the reg_addr_t typedef;
  - the ZERO_ADDR constant.
- One natural sub-module, regfile_scoreboard: pend[] vector, claim/release priority, pend_cnt, claim_err, busy lookup per port.
- Storage and read muxes stay in the top.

Test Plan:
- Reset with all entries preloaded to 0xFFFF_FFFF, then reset_n=0 one cycle -> every rd_data = 0, rd_busy = 0, pend_cnt = 0.
- Write r5 = 0x1234_5678, next cycle read port0 = r5, port1 = r0 -> rd_data0 = 0x1234_5678, rd_data1 = 0. A write of 0xDEAD to r0 leaves r0 = 0.
- BYPASS=1: same cycle wr_en, r7 = 0xA5A5_A5A5 and rd_addr0 = 7 -> rd_data0 = 0xA5A5_A5A5 combinationally. With BYPASS=0 -> old value 0.
- Claim r3 -> next cycle rd_busy = 1 for port reading r3, pend_cnt = 1. Write r3 = 0x42 -> busy drops in the write cycle (BYPASS=1); after the edge, pend_cnt = 0.
- Same cycle claim r9 and write r9 = 0x77 -> after the edge, mem[r9] = 0x77, pend[r9] = 1, pend_cnt = 1, claim_err = 0. A second claim of r9 with no write -> claim_err = 1 for one cycle, pend_cnt stays 1.
- Claim r1, r2, r4 over three cycles, then reset_n=0 mid-sequence -> pend_cnt = 0, all rd_busy = 0, r1 = 0.
